nios2_oci_dct_unpacker: RTL and testbench

- Receive-side counterpart of the OCI debug compressed-trace (DCT) packer.
- Accepts packed 30-bit DCT buffers, each holding up to 15 two-bit trace frames, together with their 4-bit valid-frame count.
- Queues buffers in a small FIFO and replays the frames one per handshake, LSB-first, to a downstream trace consumer or simulation monitor.
- Sits beside the processor OCI trace path in the Nios II subsystem.

---
 rtl/nios2_oci_dct_unpacker.sv | 82 ++++++++
 tb/tb_nios2_oci_dct_unpacker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nios2_oci_dct_unpacker.sv
// nios2_oci_dct_unpacker: queues packed 30-bit DCT buffers and replays their
// 2-bit trace frames LSB-first, one per valid/ready handshake.
module nios2_oci_dct_unpacker #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [29:0]      dct_buffer,
    input  logic [3:0]       dct_count,
    input  logic             dct_load,
    output logic             dct_ready,
    output logic [1:0]       frame_data,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             frame_last,
    output logic             overflow,
    input  logic             clr_overflow,
    output logic             idle,
    output logic [CNT_W-1:0] frames_out
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_nxt;
    logic [33:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic [29:0] shift_reg;
    logic [3:0]  remaining;
    logic        empty, full, hs, pop, push, drop, load_nz;
    logic [33:0] head;

    assign empty       = wptr == rptr;
    assign full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head        = mem[rptr[AW-1:0]];
    assign load_nz     = dct_load && (dct_count != 4'd0);
    // a full FIFO still accepts a load when the head leaves in the same cycle
    assign push        = load_nz && (!full || pop);
    assign drop        = load_nz && full && !pop;
    assign hs          = (state == SHIFT) && frame_ready;
    assign frame_valid = state == SHIFT;
    assign frame_data  = frame_valid ? shift_reg[1:0] : 2'b00;
    assign frame_last  = frame_valid && (remaining == 4'd1);
    assign dct_ready   = !full;
    assign idle        = (state == IDLE) && empty;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        if (state == IDLE) begin
            pop       = !empty;
            state_nxt = empty ? IDLE : SHIFT;
        end else if (hs && remaining == 4'd1) begin
            pop       = !empty;
            state_nxt = empty ? IDLE : SHIFT;
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wptr[AW-1:0]] <= {dct_buffer, dct_count};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            shift_reg  <= '0;
            remaining  <= '0;
            overflow   <= 1'b0;
            frames_out <= '0;
        end else begin
            state      <= state_nxt;
            wptr       <= wptr + (AW+1)'(push);
            rptr       <= rptr + (AW+1)'(pop);
            shift_reg  <= pop ? head[33:4] : hs ? shift_reg >> 2 : shift_reg;
            remaining  <= pop ? head[3:0] : hs ? remaining - 4'd1 : remaining;
            overflow   <= drop ? 1'b1 : clr_overflow ? 1'b0 : overflow;
            frames_out <= frames_out + CNT_W'(hs);
        end
    end
endmodule

// File: tb/tb_nios2_oci_dct_unpacker.sv
// tb_nios2_oci_dct_unpacker: directed stimulus with a frame scoreboard checked
// by an independent monitor on the falling clock edge.
module tb_nios2_oci_dct_unpacker;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [29:0] dct_buffer = '0;
    logic [3:0]  dct_count = '0;
    logic        dct_load = 1'b0;
    logic        dct_ready;
    logic [1:0]  frame_data;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        frame_last;
    logic        overflow;
    logic        clr_overflow = 1'b0;
    logic        idle;
    logic [15:0] frames_out;

    int          errors = 0;
    int          checks = 0;
    logic [2:0]  exp_q[$];
    logic        stalled = 1'b0;
    logic [2:0]  held;

    nios2_oci_dct_unpacker #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_load(dct_load), .dct_ready(dct_ready), .frame_data(frame_data),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_last(frame_last),
        .overflow(overflow), .clr_overflow(clr_overflow), .idle(idle), .frames_out(frames_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [29:0] b, input logic [3:0] c);
        for (int k = 0; k < int'(c); k++)
            exp_q.push_back({k == int'(c) - 1, b[2*k +: 2]});
    endtask

    task automatic load(input logic [29:0] b, input logic [3:0] c, input logic expect_kept);
        if (expect_kept) push_exp(b, c);
        dct_buffer = b;
        dct_count  = c;
        dct_load   = 1'b1;
        tick();
        dct_load   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(idle && exp_q.size() == 0) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 300), 32'd1);
    endtask

    task automatic wait_frames(input logic [15:0] target);
        int n;
        n = 0;
        while (frames_out != target && n < 100) begin
            tick();
            n++;
        end
        chk("frames_wait_timeout", 32'(n < 100), 32'd1);
    endtask

    // scoreboard monitor: every accepted frame must match the head of the queue
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled && frame_valid)
                chk("held_stable", {29'd0, frame_last, frame_data}, {29'd0, held});
            if (frame_valid && frame_ready) begin
                if (exp_q.size() == 0) chk("unexpected_frame", 32'd1, 32'd0);
                else chk("frame", {29'd0, frame_last, frame_data}, {29'd0, exp_q.pop_front()});
            end
            stalled = frame_valid && !frame_ready;
            held    = {frame_last, frame_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_last", 32'(frame_last), 32'd0);
        chk("rst_data", 32'(frame_data), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frames_out", 32'(frames_out), 32'd0);
        chk("rst_dct_ready", 32'(dct_ready), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
        #11 reset_n = 1'b1;
        tick();

        // single buffer, two-cycle latency
        frame_ready = 1'b1;
        load(30'h0000_00E4, 4'd4, 1'b1);
        chk("lat_valid_early", 32'(frame_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(frame_valid), 32'd1);
        chk("lat_first_data", 32'(frame_data), 32'd0);
        wait_idle();
        chk("single_frames_out", 32'(frames_out), 32'd4);
        chk("single_idle", 32'(idle), 32'd1);

        // backpressure with ready pattern 1,0,0,1
        frame_ready = 1'b0;
        load(30'h0000_00E4, 4'd4, 1'b1);
        for (int i = 0; i < 24; i++) begin
            frame_ready = (i % 4 == 0) || (i % 4 == 3);
            tick();
        end
        frame_ready = 1'b1;
        wait_idle();
        chk("bp_frames_out", 32'(frames_out), 32'd8);

        // back-to-back buffers with no bubble
        load(30'h6, 4'd2, 1'b1);
        load(30'h1B, 4'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("b2b_valid", 32'(frame_valid), 32'd1);
            tick();
        end
        chk("b2b_end_valid", 32'(frame_valid), 32'd0);
        wait_idle();
        chk("b2b_frames_out", 32'(frames_out), 32'd13);

        // zero-count load is ignored
        load(30'h5, 4'd0, 1'b0);
        repeat (3) tick();
        chk("zero_idle", 32'(idle), 32'd1);
        chk("zero_frames_out", 32'(frames_out), 32'd13);

        // full 15-frame buffer
        load(30'h3FFF_FFFF, 4'd15, 1'b1);
        wait_idle();
        chk("full15_frames_out", 32'(frames_out), 32'd28);

        // overflow: one buffer in the serializer, four queued, the rest dropped
        frame_ready = 1'b0;
        load(30'h0, 4'd1, 1'b1);
        repeat (3) tick();
        chk("ovf_ready_room", 32'(dct_ready), 32'd1);
        load(30'h1, 4'd1, 1'b1);
        load(30'h2, 4'd1, 1'b1);
        load(30'h3, 4'd1, 1'b1);
        load(30'h1, 4'd1, 1'b1);
        chk("ovf_ready_full", 32'(dct_ready), 32'd0);
        chk("ovf_not_yet", 32'(overflow), 32'd0);
        load(30'h2, 4'd1, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);
        clr_overflow = 1'b1;
        load(30'h3, 4'd1, 1'b0);
        clr_overflow = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_clear2", 32'(overflow), 32'd0);
        frame_ready = 1'b1;
        wait_idle();
        chk("ovf_frames_out", 32'(frames_out), 32'd33);

        // reset in the middle of an 8-frame buffer
        load(30'h0000_E4E4, 4'd8, 1'b1);
        wait_frames(16'd35);
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_valid", 32'(frame_valid), 32'd0);
        chk("mid_rst_frames_out", 32'(frames_out), 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        #2 reset_n = 1'b1;
        repeat (10) tick();
        chk("post_rst_idle", 32'(idle), 32'd1);
        chk("post_rst_frames_out", 32'(frames_out), 32'd0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
